mat2x2_inv_seq: RTL and testbench
=================================

# mat2x2_inv_seq

Sequential 2x2 signed fixed-point matrix inverter. It is the inverse-direction companion to the combinational 4x2·2x2 multiplier: it turns a 2x2 coefficient matrix B into B⁻¹, so the datapath can undo a prior matrix transform. The determinant is computed in one cycle. The four adjugate/determinant quotients are produced one at a time by a single shared bit-serial divider. A valid/ready handshake is used on both input and output.

## Interface
Parameters:
- `W`, 16: element width, signed two's complement.
- `FRAC`, 8: fractional bits. Inputs and outputs are both Q(W-FRAC).FRAC.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: B0..B3 are valid.
- `in_ready`, out, 1: block is idle and can accept a matrix.
- `B0`,`B1`,`B2`,`B3`, in, W each: B = [[B0,B1],[B2,B3]], signed.
- `out_valid`, out, 1: R0..R3 and `singular` are valid.
- `out_ready`, in, 1: consumer accepts the result.
- `R0`,`R1`,`R2`,`R3`, out, W each: B⁻¹ in row-major order, signed, saturated.
- `singular`, out, 1: det == 0. Qualified by `out_valid`.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1. On `in_valid`, latch B0..B3 and go to DET.
  - DET: det = B0·B3 − B1·B2, held as 2W+1 bits.
    - If det == 0: R0..R3=0, `singular`=1, go to DONE.
    - Otherwise: k=0, go to LOAD.
  - LOAD: select numerator adj[k]. adj = [B3, −B1, −B2, B0], sign-extended to W+1 bits, so that −(−32768) is representable. Load the divider with |adj[k]|·2^(2·FRAC) (NUMW = W+1+2·FRAC bits) and divisor |det|. Record sign = sign(adj[k]) XOR sign(det). Go to DIV.
  - DIV: one restoring-division quotient bit per cycle, for NUMW cycles. On the last bit, write R[k] and go to LOAD with k+1. After k=3, go to DONE.
  - DONE: `out_valid`=1. Outputs are held stable until `out_ready`, then return to IDLE.
- Quotient rules:
  - Truncate toward zero: magnitude division, then apply the sign.
  - Saturation: a positive magnitude above 2^(W−1)−1 gives 32767. A negative magnitude above 2^(W−1) gives −32768.
  - A zero numerator gives 0 regardless of sign.
- No new input is accepted while busy. `in_valid` outside IDLE is ignored.
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `singular`=0, R0..R3=0, k=0.
- Reset mid-operation: the computation is abandoned. The next cycle shows the reset values, and no partial result is ever presented.

## Timing
- Cycle 0 is the input handshake cycle (`in_valid`&&`in_ready`). DET is in cycle 1.
- Non-singular case: `out_valid` rises in cycle 2 + 4·(NUMW+1). With the defaults (NUMW=33) that is cycle 138.
- Singular case: `out_valid` rises in cycle 2.
- Output handshake: the transfer occurs in the cycle where `out_valid`&&`out_ready`. `in_ready` returns to 1 in the next cycle, so the minimum spacing between accepted matrices equals the latency plus 1.
- If `out_ready` is already high when `out_valid` rises, `out_valid` is high for exactly one cycle.
- R[k] registers update only at the end of their DIV phase. They are all stable while `out_valid`=1.

## Structure
- Package `mat_pkg`:
  - Constants W, FRAC, and NUMW = W+1+2·FRAC.
  - State enum {IDLE, DET, LOAD, DIV, DONE}.
  - A saturation function from magnitude+sign to W bits.
- Sub-module `seq_udiv`: unsigned restoring divider with parameter NUMW.
  - Ports: `start`, `dividend`, `divisor`, `done`, `quotient`.
  - Produces one bit per cycle and is reused for all four elements.
- Top level holds the FSM, the det multiplier/subtractor, and the sign and saturation logic.

## Test plan
- B=[256,0,0,256] (identity) -> R=[256,0,0,256], `singular`=0, `out_valid` at cycle 138.
- B=[512,0,0,1024] -> R=[128,0,0,64]. B=[768,0,0,768] -> R0=R3=85 (truncated 85.33).
- B=[0,256,256,0] (det=−65536) -> R=[0,256,256,0]. This checks the sign path, including −adj over −det.
- B=[256,256,256,256] -> `singular`=1, R=[0,0,0,0], `out_valid` at cycle 2. B=[1,0,0,1] -> R0=R3=32767 (saturated).
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` -> outputs stable, `in_ready`=0, a new `in_valid` is ignored. Then pulse `out_ready` -> `in_ready`=1 on the next cycle.
- Assert `rst` for 1 cycle during DIV of k=2 -> all reset values, no `out_valid`. The next identity input yields the correct result.

Source files
------------

// File: rtl/mat2x2_inv_seq_pkg.sv
// rtl/mat2x2_inv_seq_pkg.sv - shared constants, FSM states and quotient saturation for mat2x2_inv_seq
package mat_pkg;

   localparam int W    = 16;
   localparam int FRAC = 8;
   localparam int NUMW = W + 1 + 2 * FRAC;
   localparam int DENW = 2 * W + 1;
   localparam int MAXP = 2 ** (W - 1) - 1;

   typedef enum logic [2:0] {
      IDLE,
      DET,
      LOAD,
      DIV,
      DONE
   } state_t;

   // Magnitude quotient plus sign to a saturated W-bit two's complement value.
   function automatic logic [W-1:0] sat_w(input logic [NUMW-1:0] mag, input logic neg);
      logic [W-1:0] res;
      if (mag == '0) begin
         res = '0;
      end else if (!neg) begin
         res = (mag > NUMW'(MAXP)) ? W'(MAXP) : W'(mag);
      end else begin
         res = (mag > NUMW'(MAXP + 1)) ? {1'b1, {(W-1){1'b0}}} : W'(-mag);
      end
      return res;
   endfunction

endpackage

// File: rtl/mat2x2_inv_seq_if.sv
// rtl/mat2x2_inv_seq_if.sv - matrix in / inverse out handshake bundle
interface mat2x2_inv_seq_if #(parameter int W = mat_pkg::W);

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] B0, B1, B2, B3;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] R0, R1, R2, R3;
   logic         singular;
   logic         busy;

   modport master (
      output in_valid, B0, B1, B2, B3, out_ready,
      input  in_ready, out_valid, R0, R1, R2, R3, singular, busy
   );

   modport slave (
      input  in_valid, B0, B1, B2, B3, out_ready,
      output in_ready, out_valid, R0, R1, R2, R3, singular, busy
   );

endinterface

// File: rtl/mat2x2_inv_seq_udiv.sv
// rtl/mat2x2_inv_seq_udiv.sv - unsigned restoring divider, one quotient bit per cycle
module seq_udiv #(
   parameter int NUMW = 33,
   parameter int DENW = 33
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [NUMW-1:0] dividend,
   input  logic [DENW-1:0] divisor,
   output logic            done,
   output logic [NUMW-1:0] quotient
);

   localparam int CW = $clog2(NUMW);

   logic [DENW-1:0] rem_q, rem_d, dsr_q, dsr_d, rem_step;
   logic [NUMW-1:0] num_q, num_d, quo_q, quo_d, quo_step;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            act_q, act_d;
   logic [DENW:0]   trial, diff;
   logic            ge, unused_rem_msb;

   always_comb begin
      trial    = {rem_q, num_q[NUMW-1]};
      diff     = trial - {1'b0, dsr_q};
      ge       = trial >= {1'b0, dsr_q};
      // Remainder stays below the divisor, so the top bit is always zero.
      {unused_rem_msb, rem_step} = ge ? diff : trial;
      quo_step = {quo_q[NUMW-2:0], ge};

      rem_d = rem_q;
      dsr_d = dsr_q;
      num_d = num_q;
      quo_d = quo_q;
      cnt_d = cnt_q;
      act_d = act_q;
      if (start) begin
         rem_d = '0;
         dsr_d = divisor;
         num_d = dividend;
         quo_d = '0;
         cnt_d = '0;
         act_d = 1'b1;
      end else if (act_q) begin
         rem_d = rem_step;
         num_d = num_q << 1;
         quo_d = quo_step;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(NUMW - 1)) act_d = 1'b0;
      end
   end

   assign done     = act_q && (cnt_q == CW'(NUMW - 1));
   assign quotient = quo_step;

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         dsr_q <= '0;
         num_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
         act_q <= 1'b0;
      end else begin
         rem_q <= rem_d;
         dsr_q <= dsr_d;
         num_q <= num_d;
         quo_q <= quo_d;
         cnt_q <= cnt_d;
         act_q <= act_d;
      end
   end

endmodule

// File: rtl/mat2x2_inv_seq.sv
// rtl/mat2x2_inv_seq.sv - sequential 2x2 fixed-point matrix inverter with shared serial divider
module mat2x2_inv_seq
   import mat_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   mat2x2_inv_seq_if.slave   bus
);

   state_t state_q, state_d;

   logic signed [W-1:0] b_q [4];
   logic signed [W-1:0] b_d [4];
   logic [W-1:0]        r_q [4];
   logic [W-1:0]        r_d [4];
   logic signed [2*W:0] det_q, det_d, det_c;
   logic [1:0]          k_q, k_d;
   logic                sing_q, sing_d;
   logic                sign_q, sign_d;

   logic signed [W:0]   adj;
   logic [W:0]          abs_adj;
   logic [DENW-1:0]     abs_det;
   logic [NUMW-1:0]     div_num, div_quot;
   logic                div_start, div_done;

   always_comb begin
      det_c = (2*W+1)'($signed(b_q[0])) * (2*W+1)'($signed(b_q[3]))
            - (2*W+1)'($signed(b_q[1])) * (2*W+1)'($signed(b_q[2]));
      // Adjugate numerators are W+1 bits wide so that negating -2^(W-1) cannot overflow.
      case (k_q)
         2'd0:    adj = (W+1)'($signed(b_q[3]));
         2'd1:    adj = -((W+1)'($signed(b_q[1])));
         2'd2:    adj = -((W+1)'($signed(b_q[2])));
         default: adj = (W+1)'($signed(b_q[0]));
      endcase
      abs_adj = adj[W] ? -adj : adj;
      abs_det = det_q[2*W] ? -det_q : det_q;
      div_num = {abs_adj, {(2*FRAC){1'b0}}};
   end

   seq_udiv #(.NUMW(NUMW), .DENW(DENW)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (div_num),
      .divisor  (abs_det),
      .done     (div_done),
      .quotient (div_quot)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.in_valid) state_d = DET;
         DET:  state_d = (det_c == '0) ? DONE : LOAD;
         LOAD: state_d = DIV;
         DIV:  if (div_done) state_d = (k_q == 2'd3) ? DONE : LOAD;
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.busy      = (state_q != IDLE);
      bus.singular  = sing_q;
      bus.R0        = r_q[0];
      bus.R1        = r_q[1];
      bus.R2        = r_q[2];
      bus.R3        = r_q[3];
      div_start     = (state_q == LOAD);
   end

   always_comb begin
      b_d    = b_q;
      r_d    = r_q;
      det_d  = det_q;
      k_d    = k_q;
      sing_d = sing_q;
      sign_d = sign_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               b_d[0] = bus.B0;
               b_d[1] = bus.B1;
               b_d[2] = bus.B2;
               b_d[3] = bus.B3;
            end
         end
         DET: begin
            det_d  = det_c;
            k_d    = 2'd0;
            sing_d = (det_c == '0);
            if (det_c == '0) begin
               for (int i = 0; i < 4; i++) r_d[i] = '0;
            end
         end
         LOAD: sign_d = adj[W] ^ det_q[2*W];
         DIV: begin
            if (div_done) begin
               r_d[k_q] = sat_w(div_quot, sign_q);
               k_d      = k_q + 2'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            b_q[i] <= '0;
            r_q[i] <= '0;
         end
         det_q  <= '0;
         k_q    <= 2'd0;
         sing_q <= 1'b0;
         sign_q <= 1'b0;
      end else begin
         b_q    <= b_d;
         r_q    <= r_d;
         det_q  <= det_d;
         k_q    <= k_d;
         sing_q <= sing_d;
         sign_q <= sign_d;
      end
   end

endmodule

// File: tb/tb_mat2x2_inv_seq.sv
// tb/tb_mat2x2_inv_seq.sv - directed vector bench for mat2x2_inv_seq
module tb_mat2x2_inv_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mat2x2_inv_seq_if bus ();

   mat2x2_inv_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int b0, b1, b2, b3;
      int r0, r1, r2, r3;
      int sing;
      int lat;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input int b0, b1, b2, b3, r0, r1, r2, r3, sing, lat);
      vec_t v;
      v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3;
      v.r0 = r0; v.r1 = r1; v.r2 = r2; v.r3 = r3;
      v.sing = sing; v.lat = lat;
      return v;
   endfunction

   task automatic drive_b(input vec_t v);
      bus.B0 = 16'(v.b0);
      bus.B1 = 16'(v.b1);
      bus.B2 = 16'(v.b2);
      bus.B3 = 16'(v.b3);
   endtask

   task automatic send(input vec_t v, input string tag, output int lat);
      int w = 0;
      while (!bus.in_ready && w < 300) begin
         tick();
         w++;
      end
      chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
      drive_b(v);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 400) begin
         tick();
         lat++;
      end
   endtask

   task automatic check_result(input vec_t v, input int lat, input string tag);
      chk({tag, "_latency"}, lat, v.lat);
      chk({tag, "_R0"}, int'($signed(bus.R0)), v.r0);
      chk({tag, "_R1"}, int'($signed(bus.R1)), v.r1);
      chk({tag, "_R2"}, int'($signed(bus.R2)), v.r2);
      chk({tag, "_R3"}, int'($signed(bus.R3)), v.r3);
      chk({tag, "_singular"}, int'(bus.singular), v.sing);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
      chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
      chk({tag, "_busy"}, int'(bus.busy), 0);
      chk({tag, "_singular"}, int'(bus.singular), 0);
      chk({tag, "_R0"}, int'(bus.R0), 0);
      chk({tag, "_R1"}, int'(bus.R1), 0);
      chk({tag, "_R2"}, int'(bus.R2), 0);
      chk({tag, "_R3"}, int'(bus.R3), 0);
   endtask

   vec_t vecs [10];
   vec_t ident;
   vec_t sing_m;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int seen;

      ident  = mk(256, 0, 0, 256, 256, 0, 0, 256, 0, 138);
      sing_m = mk(256, 256, 256, 256, 0, 0, 0, 0, 1, 2);
      vecs[0] = ident;
      vecs[1] = mk(512, 0, 0, 1024, 128, 0, 0, 64, 0, 138);
      vecs[2] = mk(768, 0, 0, 768, 85, 0, 0, 85, 0, 138);
      vecs[3] = mk(0, 256, 256, 0, 0, 256, 256, 0, 0, 138);
      vecs[4] = sing_m;
      vecs[5] = mk(1, 0, 0, 1, 32767, 0, 0, 32767, 0, 138);
      vecs[6] = mk(-1, 0, 0, 1, -32768, 0, 0, 32767, 0, 138);
      vecs[7] = mk(512, 256, 256, 512, 170, -85, -85, 170, 0, 138);
      vecs[8] = mk(-32768, 0, 0, -32768, -2, 0, 0, -2, 0, 138);
      vecs[9] = mk(0, -32768, 256, 0, 0, 256, -2, 0, 0, 138);

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drive_b(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_reset_state("reset");

      for (int i = 0; i < 10; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         send(vecs[i], tag, lat);
         check_result(vecs[i], lat, tag);
         tick();
         chk({tag, "_valid_one_cycle"}, int'(bus.out_valid), 0);
         chk({tag, "_in_ready_after"}, int'(bus.in_ready), 1);
      end

      // Backpressure: result must hold while a competing input is offered.
      bus.out_ready = 1'b0;
      send(ident, "bp", lat);
      check_result(ident, lat, "bp");
      for (int c = 0; c < 10; c++) begin
         drive_b(sing_m);
         bus.in_valid = 1'b1;
         tick();
         chk("bp_out_valid", int'(bus.out_valid), 1);
         chk("bp_in_ready", int'(bus.in_ready), 0);
         chk("bp_R0", int'($signed(bus.R0)), 256);
         chk("bp_R3", int'($signed(bus.R3)), 256);
         chk("bp_singular", int'(bus.singular), 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("bp_release_in_ready", int'(bus.in_ready), 1);
      chk("bp_release_out_valid", int'(bus.out_valid), 0);
      tick();
      chk("bp_release_busy", int'(bus.busy), 0);

      // Reset during the third division phase.
      drive_b(ident);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int c = 1; c < 85; c++) tick();
      chk("mid_busy", int'(bus.busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_state("mid_reset");
      seen = 0;
      for (int c = 0; c < 150; c++) begin
         tick();
         if (bus.out_valid) seen = 1;
      end
      chk("mid_reset_no_valid", seen, 0);
      send(ident, "post_reset", lat);
      check_result(ident, lat, "post_reset");
      tick();
      chk("post_reset_ack", int'(bus.out_valid), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
